mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one data-memory request port between the pipeline MEM stage and a
// DMA/debug requester. The pipeline normally wins. DMA wins when it has been
// passed over STARVE_LIMIT times in a row while waiting. A transaction that
// gets no memAck within TIMEOUT busy cycles is aborted. An aborted read
// returns 32'hDEADBEEF and sets the sticky errFlag.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   pipeMemCtrl         MEM-stage control (bit0 read, bit1 write, 11 = write)
//   pipeAddr/pipeWdata  MEM-stage address and store data
//   pipeStall           freezes the pipeline while its access is outstanding
//   pipeRdata           registered load data for the WB stage
//   dmaReq/dmaWe        DMA request (held until dmaDone) and write enable
//   dmaAddr/dmaWdata    DMA address and store data
//   dmaDone/dmaRdata    one-cycle completion pulse and registered load data
//   memReq/memWe        memory request and write enable
//   memAddr/memWdata    latched memory address and store data
//   memAck/memRdata     memory completion and read data
//   errFlag/errClr      sticky timeout error and its clear
module mem_port_arbiter #(
   parameter int TIMEOUT      = 15,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  pipeMemCtrl,
   input  logic [31:0] pipeAddr,
   input  logic [31:0] pipeWdata,
   output logic        pipeStall,
   output logic [31:0] pipeRdata,
   input  logic        dmaReq,
   input  logic        dmaWe,
   input  logic [31:0] dmaAddr,
   input  logic [31:0] dmaWdata,
   output logic        dmaDone,
   output logic [31:0] dmaRdata,
   output logic        memReq,
   output logic        memWe,
   output logic [31:0] memAddr,
   output logic [31:0] memWdata,
   input  logic        memAck,
   input  logic [31:0] memRdata,
   output logic        errFlag,
   input  logic        errClr
);

   localparam int CNT_W    = $clog2(TIMEOUT + 1);
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PIPE = 2'd1,
      DMA  = 2'd2
   } state_t;

   state_t              state;
   state_t              stateNext;
   logic [CNT_W-1:0]    cycCnt;
   logic [STARVE_W-1:0] starveCnt;
   logic                pipeWants;
   logic                dmaEff;
   logic                starveFull;
   logic                busy;
   logic                timeout;
   logic                finish;
   logic                grantPipe;
   logic                grantDma;

   // Request qualification and transaction-end detection. dmaReq stays high
   // during the dmaDone cycle because the requester only sees dmaDone then.
   // That cycle's request is masked so a finished DMA is not granted twice.
   // A memAck in the final busy cycle completes the transfer normally
   // instead of aborting it.
   always_comb begin
      pipeWants  = (pipeMemCtrl != 2'b00);
      dmaEff     = dmaReq && !dmaDone;
      starveFull = (starveCnt == STARVE_W'(STARVE_LIMIT));
      busy       = (state != IDLE);
      timeout    = busy && !memAck && (cycCnt == CNT_W'(TIMEOUT - 1));
      finish     = busy && (memAck || timeout);
      memReq     = busy;
      pipeStall  = pipeWants && !((state == PIPE) && (memAck || timeout));
   end

   // Arbitration. Grants only happen from IDLE. Every completion or abort
   // therefore passes through at least one IDLE cycle before the next grant.
   always_comb begin
      stateNext = state;
      grantPipe = 1'b0;
      grantDma  = 1'b0;
      case (state)
         IDLE: begin
            if (pipeWants && !(dmaEff && starveFull)) begin
               grantPipe = 1'b1;
               stateNext = PIPE;
            end else if (dmaEff) begin
               grantDma  = 1'b1;
               stateNext = DMA;
            end
         end
         PIPE, DMA: begin
            if (finish) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // State register. The asynchronous reset drops any transaction at once,
   // so memReq falls without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Datapath. The request is latched at grant and held until exit, so
   // requester inputs cannot disturb an access already in flight. Read data
   // (or the abort pattern) is captured on the edge that ends the access.
   // dmaDone is the registered form of that same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycCnt    <= '0;
         starveCnt <= '0;
         memWe     <= 1'b0;
         memAddr   <= '0;
         memWdata  <= '0;
         pipeRdata <= '0;
         dmaDone   <= 1'b0;
         dmaRdata  <= '0;
         errFlag   <= 1'b0;
      end else begin
         dmaDone <= 1'b0;

         if (timeout) begin
            errFlag <= 1'b1;
         end else if (errClr) begin
            errFlag <= 1'b0;
         end

         if (!dmaEff || grantDma) begin
            starveCnt <= '0;
         end else if (grantPipe && !starveFull) begin
            starveCnt <= starveCnt + 1'b1;
         end

         if (grantPipe) begin
            memWe    <= pipeMemCtrl[1];
            memAddr  <= pipeAddr;
            memWdata <= pipeWdata;
         end else if (grantDma) begin
            memWe    <= dmaWe;
            memAddr  <= dmaAddr;
            memWdata <= dmaWdata;
         end

         if (grantPipe || grantDma) begin
            cycCnt <= '0;
         end else if (busy && !memAck && !timeout) begin
            cycCnt <= cycCnt + 1'b1;
         end

         if ((state == PIPE) && finish && !memWe) begin
            pipeRdata <= memAck ? memRdata : ABORT_DATA;
         end

         if ((state == DMA) && finish) begin
            dmaDone <= 1'b1;
            if (!memWe) begin
               dmaRdata <= memAck ? memRdata : ABORT_DATA;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int TIMEOUT      = 15;
   localparam int STARVE_LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  pipeMemCtrl;
   logic [31:0] pipeAddr;
   logic [31:0] pipeWdata;
   logic        pipeStall;
   logic [31:0] pipeRdata;
   logic        dmaReq;
   logic        dmaWe;
   logic [31:0] dmaAddr;
   logic [31:0] dmaWdata;
   logic        dmaDone;
   logic [31:0] dmaRdata;
   logic        memReq;
   logic        memWe;
   logic [31:0] memAddr;
   logic [31:0] memWdata;
   logic        memAck;
   logic [31:0] memRdata;
   logic        errFlag;
   logic        errClr;

   int checks = 0;
   int errors = 0;

   // 100 MHz free-running clock.
   always #5 clk = ~clk;

   mem_port_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .rst(rst),
      .pipeMemCtrl(pipeMemCtrl), .pipeAddr(pipeAddr), .pipeWdata(pipeWdata),
      .pipeStall(pipeStall), .pipeRdata(pipeRdata),
      .dmaReq(dmaReq), .dmaWe(dmaWe), .dmaAddr(dmaAddr), .dmaWdata(dmaWdata),
      .dmaDone(dmaDone), .dmaRdata(dmaRdata),
      .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
      .memAck(memAck), .memRdata(memRdata),
      .errFlag(errFlag), .errClr(errClr)
   );

   // One table row is the input set for one cycle plus the outputs expected in that cycle.
   typedef struct {
      logic [1:0]  c;
      logic [31:0] a;
      logic [31:0] wd;
      logic        dr;
      logic [31:0] da;
      logic        ak;
      logic [31:0] rd;
      logic        eReq;
      logic        eWe;
      logic [31:0] eAddr;
      logic        eStall;
      logic [31:0] ePr;
      logic        eDone;
      logic [31:0] eDr;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mk(input logic [1:0] c, input logic [31:0] a, input logic [31:0] wd,
                               input logic dr, input logic [31:0] da, input logic ak,
                               input logic [31:0] rd, input logic eReq, input logic eWe,
                               input logic [31:0] eAddr, input logic eStall,
                               input logic [31:0] ePr, input logic eDone, input logic [31:0] eDr);
      vec_t v;
      v.c = c; v.a = a; v.wd = wd; v.dr = dr; v.da = da; v.ak = ak; v.rd = rd;
      v.eReq = eReq; v.eWe = eWe; v.eAddr = eAddr; v.eStall = eStall;
      v.ePr = ePr; v.eDone = eDone; v.eDr = eDr;
      return v;
   endfunction

   // Compares one observed value with its expected value and records any failure.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives all requester and memory inputs from one table row.
   task automatic applyStimulus(input vec_t v);
      pipeMemCtrl = v.c;
      pipeAddr    = v.a;
      pipeWdata   = v.wd;
      dmaReq      = v.dr;
      dmaWe       = 1'b0;
      dmaAddr     = v.da;
      dmaWdata    = 32'h0;
      memAck      = v.ak;
      memRdata    = v.rd;
      errClr      = 1'b0;
   endtask

   // Reference model kept at the transaction level: who owns the port,
   // the request latched for it, and how many busy cycles it has used.
   int          mOwner;
   int          mBusy;
   int          mStarve;
   logic        mWe;
   logic [31:0] mAddr;
   logic [31:0] mWdata;
   logic [31:0] mPipeRdata;
   logic [31:0] mDmaRdata;
   logic        mDone;
   logic        mErr;

   task automatic modelReset();
      mOwner = 0; mBusy = 0; mStarve = 0;
      mWe = 1'b0; mAddr = 32'h0; mWdata = 32'h0;
      mPipeRdata = 32'h0; mDmaRdata = 32'h0; mDone = 1'b0; mErr = 1'b0;
   endtask

   function automatic logic modelStall();
      logic releaseNow;
      releaseNow = (mOwner == 1) && (memAck || mBusy == TIMEOUT);
      return (pipeMemCtrl != 2'b00) && !releaseNow;
   endfunction

   task automatic modelStep();
      logic dmaOk;
      logic abortNow;
      logic endsNow;
      logic newDone;
      dmaOk    = dmaReq && !mDone;
      abortNow = (mOwner != 0) && !memAck && (mBusy == TIMEOUT);
      endsNow  = (mOwner != 0) && (memAck || abortNow);
      newDone  = 1'b0;
      if (abortNow) mErr = 1'b1;
      else if (errClr) mErr = 1'b0;
      if (mOwner == 0) begin
         if ((pipeMemCtrl != 2'b00) && !(dmaOk && mStarve == STARVE_LIMIT)) begin
            mOwner = 1; mBusy = 1;
            mWe = pipeMemCtrl[1]; mAddr = pipeAddr; mWdata = pipeWdata;
            if (!dmaOk) mStarve = 0;
            else if (mStarve < STARVE_LIMIT) mStarve = mStarve + 1;
         end else if (dmaOk) begin
            mOwner = 2; mBusy = 1;
            mWe = dmaWe; mAddr = dmaAddr; mWdata = dmaWdata;
            mStarve = 0;
         end else begin
            mStarve = 0;
         end
      end else begin
         if (!dmaOk) mStarve = 0;
         if (endsNow) begin
            if (!mWe && mOwner == 1) mPipeRdata = memAck ? memRdata : 32'hDEADBEEF;
            if (!mWe && mOwner == 2) mDmaRdata = memAck ? memRdata : 32'hDEADBEEF;
            if (mOwner == 2) newDone = 1'b1;
            mOwner = 0;
         end else begin
            mBusy = mBusy + 1;
         end
      end
      mDone = newDone;
   endtask

   // Continuous pipe reads compete with a held DMA request. The first
   // STARVE_LIMIT grants go to the pipe and the next one goes to DMA.
   task automatic runStarve(input string tag);
      int   grants;
      int   cyc;
      logic prevReq;
      grants = 0; cyc = 0; prevReq = 1'b0;
      pipeMemCtrl = 2'b01; pipeAddr = 32'h400; dmaReq = 1'b1; dmaWe = 1'b0;
      dmaAddr = 32'h500; memAck = 1'b1; memRdata = 32'h0BADF00D;
      while (grants < STARVE_LIMIT + 1 && cyc < 60) begin
         @(negedge clk);
         if (memReq && !prevReq) begin
            grants++;
            checkOutput($sformatf("%s_grant%0d", tag, grants), memAddr,
                        (grants == STARVE_LIMIT + 1) ? 32'h500 : 32'h400);
         end
         prevReq = memReq;
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput({tag, "_grantCount"}, 32'(grants), 32'(STARVE_LIMIT + 1));
      pipeMemCtrl = 2'b00;
      @(negedge clk);
      checkOutput({tag, "_dmaDone"}, 32'(dmaDone), 32'd1);
      @(posedge clk); #1;
      dmaReq = 1'b0; memAck = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_dmaDoneOnce"}, 32'(dmaDone), 32'd0);
      @(posedge clk); #1;
   endtask

   // Main sequence.
   initial begin
      vecs[0]  = mk(2'b01, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
      vecs[1]  = mk(2'b01, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b1, 1'b0, 32'h100, 1'b1, 32'h0, 1'b0, 32'h0);
      vecs[2]  = mk(2'b01, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b1, 1'b0, 32'h100, 1'b1, 32'h0, 1'b0, 32'h0);
      vecs[3]  = mk(2'b01, 32'h100, 32'h0, 1'b0, 32'h0, 1'b1, 32'h12345678,
                    1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
      vecs[4]  = mk(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h100, 1'b0, 32'h12345678, 1'b0, 32'h0);
      vecs[5]  = mk(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF0000,
                    1'b0, 1'b0, 32'h100, 1'b0, 32'h12345678, 1'b0, 32'h0);
      vecs[6]  = mk(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h100, 1'b0, 32'h12345678, 1'b0, 32'h0);
      vecs[7]  = mk(2'b10, 32'h200, 32'hAAAA5555, 1'b1, 32'h300, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h100, 1'b1, 32'h12345678, 1'b0, 32'h0);
      vecs[8]  = mk(2'b10, 32'h200, 32'hAAAA5555, 1'b1, 32'h300, 1'b1, 32'h0,
                    1'b1, 1'b1, 32'h200, 1'b0, 32'h12345678, 1'b0, 32'h0);
      vecs[9]  = mk(2'b00, 32'h0, 32'h0, 1'b1, 32'h300, 1'b0, 32'h0,
                    1'b0, 1'b1, 32'h200, 1'b0, 32'h12345678, 1'b0, 32'h0);
      vecs[10] = mk(2'b00, 32'h0, 32'h0, 1'b1, 32'h300, 1'b1, 32'hCAFEF00D,
                    1'b1, 1'b0, 32'h300, 1'b0, 32'h12345678, 1'b0, 32'h0);
      vecs[11] = mk(2'b00, 32'h0, 32'h0, 1'b1, 32'h300, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h300, 1'b0, 32'h12345678, 1'b1, 32'hCAFEF00D);
      vecs[12] = mk(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h300, 1'b0, 32'h12345678, 1'b0, 32'hCAFEF00D);
      vecs[13] = mk(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h300, 1'b0, 32'h12345678, 1'b0, 32'hCAFEF00D);

      pipeMemCtrl = 2'b00; pipeAddr = 32'h0; pipeWdata = 32'h0;
      dmaReq = 1'b0; dmaWe = 1'b0; dmaAddr = 32'h0; dmaWdata = 32'h0;
      memAck = 1'b0; memRdata = 32'h0; errClr = 1'b0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_memReq", 32'(memReq), 32'd0);
      checkOutput("rst_memWe", 32'(memWe), 32'd0);
      checkOutput("rst_memAddr", memAddr, 32'h0);
      checkOutput("rst_pipeRdata", pipeRdata, 32'h0);
      checkOutput("rst_dmaDone", 32'(dmaDone), 32'd0);
      checkOutput("rst_errFlag", 32'(errFlag), 32'd0);
      rst = 1'b1;

      $display("[TB] table vectors");
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_memReq", i), 32'(memReq), 32'(vecs[i].eReq));
         checkOutput($sformatf("vec%0d_memWe", i), 32'(memWe), 32'(vecs[i].eWe));
         checkOutput($sformatf("vec%0d_memAddr", i), memAddr, vecs[i].eAddr);
         checkOutput($sformatf("vec%0d_pipeStall", i), 32'(pipeStall), 32'(vecs[i].eStall));
         checkOutput($sformatf("vec%0d_pipeRdata", i), pipeRdata, vecs[i].ePr);
         checkOutput($sformatf("vec%0d_dmaDone", i), 32'(dmaDone), 32'(vecs[i].eDone));
         checkOutput($sformatf("vec%0d_dmaRdata", i), dmaRdata, vecs[i].eDr);
         checkOutput($sformatf("vec%0d_errFlag", i), 32'(errFlag), 32'd0);
         @(posedge clk); #1;
      end

      $display("[TB] starvation");
      runStarve("starveA");
      runStarve("starveB");

      $display("[TB] DMA timeout");
      pipeMemCtrl = 2'b00; memAck = 1'b0; dmaReq = 1'b1; dmaWe = 1'b0; dmaAddr = 32'h700;
      @(negedge clk);
      checkOutput("to_idleReq", 32'(memReq), 32'd0);
      @(posedge clk); #1;
      for (int i = 1; i <= TIMEOUT; i++) begin
         errClr = (i == TIMEOUT);
         @(negedge clk);
         checkOutput($sformatf("to_busy%0d", i), 32'(memReq), 32'd1);
         if (i == 1) checkOutput("to_errBefore", 32'(errFlag), 32'd0);
         @(posedge clk); #1;
      end
      errClr = 1'b0;
      @(negedge clk);
      checkOutput("to_memReqDrop", 32'(memReq), 32'd0);
      checkOutput("to_dmaDone", 32'(dmaDone), 32'd1);
      checkOutput("to_dmaRdata", dmaRdata, 32'hDEADBEEF);
      checkOutput("to_errSetWins", 32'(errFlag), 32'd1);
      @(posedge clk); #1;
      dmaReq = 1'b0; errClr = 1'b1;
      @(negedge clk);
      checkOutput("to_dmaDoneOnce", 32'(dmaDone), 32'd0);
      @(posedge clk); #1;
      errClr = 1'b0;
      @(negedge clk);
      checkOutput("to_errCleared", 32'(errFlag), 32'd0);
      @(posedge clk); #1;

      $display("[TB] pipe timeout");
      pipeMemCtrl = 2'b01; pipeAddr = 32'h800;
      @(negedge clk);
      checkOutput("pto_reqStall", 32'(pipeStall), 32'd1);
      @(posedge clk); #1;
      for (int i = 1; i <= TIMEOUT; i++) begin
         @(negedge clk);
         checkOutput($sformatf("pto_stall%0d", i), 32'(pipeStall), (i == TIMEOUT) ? 32'd0 : 32'd1);
         @(posedge clk); #1;
      end
      pipeMemCtrl = 2'b00;
      @(negedge clk);
      checkOutput("pto_pipeRdata", pipeRdata, 32'hDEADBEEF);
      checkOutput("pto_memReq", 32'(memReq), 32'd0);
      checkOutput("pto_errFlag", 32'(errFlag), 32'd1);
      errClr = 1'b1;
      @(posedge clk); #1;
      errClr = 1'b0;
      @(negedge clk);
      checkOutput("pto_errCleared", 32'(errFlag), 32'd0);
      @(posedge clk); #1;

      $display("[TB] reset mid-transaction");
      pipeMemCtrl = 2'b01; pipeAddr = 32'h900;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2;
      rst = 1'b0;
      #1;
      checkOutput("mrst_memReq", 32'(memReq), 32'd0);
      checkOutput("mrst_pipeStall", 32'(pipeStall), 32'd1);
      checkOutput("mrst_memAddr", memAddr, 32'h0);
      memAck = 1'b1; memRdata = 32'h99999999;
      @(posedge clk); #1;
      checkOutput("mrst_pipeRdata", pipeRdata, 32'h0);
      checkOutput("mrst_dmaDone", 32'(dmaDone), 32'd0);
      pipeMemCtrl = 2'b00; memAck = 1'b0;
      #2;
      rst = 1'b1;
      pipeMemCtrl = 2'b01; pipeAddr = 32'hA00;
      @(negedge clk);
      checkOutput("post_idleStall", 32'(pipeStall), 32'd1);
      @(posedge clk); #1;
      memAck = 1'b1; memRdata = 32'h5A5A5A5A;
      @(negedge clk);
      checkOutput("post_memReq", 32'(memReq), 32'd1);
      checkOutput("post_memAddr", memAddr, 32'hA00);
      checkOutput("post_ackStall", 32'(pipeStall), 32'd0);
      @(posedge clk); #1;
      pipeMemCtrl = 2'b00; memAck = 1'b0;
      @(negedge clk);
      checkOutput("post_pipeRdata", pipeRdata, 32'h5A5A5A5A);
      checkOutput("post_idle", 32'(memReq), 32'd0);
      @(posedge clk); #1;

      $display("[TB] randomized run against reference model");
      rst = 1'b0;
      modelReset();
      @(posedge clk); #1;
      rst = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int ackDen;
         ackDen = (cyc < 1500) ? 3 : 14;
         pipeMemCtrl = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         pipeAddr    = $urandom();
         pipeWdata   = $urandom();
         if ($urandom_range(0, 5) == 0) dmaReq = ~dmaReq;
         dmaWe       = 1'($urandom_range(0, 1));
         dmaAddr     = $urandom();
         dmaWdata    = $urandom();
         memAck      = ($urandom_range(0, ackDen - 1) == 0);
         memRdata    = $urandom();
         errClr      = ($urandom_range(0, 19) == 0);
         @(negedge clk);
         checkOutput("rnd_memReq", 32'(memReq), 32'(mOwner != 0));
         checkOutput("rnd_memWe", 32'(memWe), 32'(mWe));
         checkOutput("rnd_memAddr", memAddr, mAddr);
         checkOutput("rnd_memWdata", memWdata, mWdata);
         checkOutput("rnd_pipeStall", 32'(pipeStall), 32'(modelStall()));
         checkOutput("rnd_pipeRdata", pipeRdata, mPipeRdata);
         checkOutput("rnd_dmaDone", 32'(dmaDone), 32'(mDone));
         checkOutput("rnd_dmaRdata", dmaRdata, mDmaRdata);
         checkOutput("rnd_errFlag", 32'(errFlag), 32'(mErr));
         @(posedge clk);
         modelStep();
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog in case the main sequence stalls.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
